// File: rtl/countdown_display.sv
// Display/alarm back-end for the two-digit BCD countdown timer: input resync,
// multiplexed common-anode 7-segment scan, alarm blink and buzzer tone.
module countdown_display #(
  parameter int SCAN_DIV  = 25000,
  parameter int TONE_DIV  = 12500,
  parameter int BLINK_DIV = 12500000,
  parameter int BLANK_LZ  = 1
) (
  input  logic       clock_50,
  input  logic       reset,
  input  logic [3:0] TimeH,
  input  logic [3:0] TimeL,
  input  logic       beep,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       buzzer,
  output logic       err
);

  localparam int SCAN_W  = $clog2(SCAN_DIV);
  localparam int TONE_W  = $clog2(TONE_DIV);
  localparam int BLINK_W = $clog2(BLINK_DIV);

  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [TONE_W-1:0]  TONE_LAST  = TONE_W'(TONE_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] digit);
    logic [6:0] pattern;
    case (digit)
      4'd0:    pattern = 7'h40;
      4'd1:    pattern = 7'h79;
      4'd2:    pattern = 7'h24;
      4'd3:    pattern = 7'h30;
      4'd4:    pattern = 7'h19;
      4'd5:    pattern = 7'h12;
      4'd6:    pattern = 7'h02;
      4'd7:    pattern = 7'h78;
      4'd8:    pattern = 7'h00;
      4'd9:    pattern = 7'h10;
      default: pattern = SEG_DASH;
    endcase
    return pattern;
  endfunction

  logic [8:0]         sync_p1, sync_p2, disp_p3;
  logic [SCAN_W-1:0]  scan_cnt;
  logic [TONE_W-1:0]  tone_cnt;
  logic [BLINK_W-1:0] blink_cnt;
  logic               digit_sel, blink_phase, tone_low;
  logic               alarm;
  logic [3:0]         digit_h, digit_l;
  logic [6:0]         seg_d;
  logic [1:0]         an_d;
  logic               buzzer_d;

  assign alarm   = disp_p3[8];
  assign digit_h = disp_p3[7:4];
  assign digit_l = disp_p3[3:0];

  // Stage p1/p2: resync from the slow counter domain; p3 accepts only a value held two cycles
  always_ff @(posedge clock_50 or negedge reset) begin
    if (!reset) begin
      sync_p1 <= '0;
      sync_p2 <= '0;
      disp_p3 <= '0;
    end else begin
      sync_p1 <= {beep, TimeH, TimeL};
      sync_p2 <= sync_p1;
      if (sync_p2 == sync_p1)
        disp_p3 <= sync_p2;
    end
  end

  always_ff @(posedge clock_50 or negedge reset) begin
    if (!reset) begin
      scan_cnt  <= '0;
      digit_sel <= 1'b0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt  <= '0;
      digit_sel <= ~digit_sel;
    end else begin
      scan_cnt  <= scan_cnt + 1'b1;
    end
  end

  // Dropping the alarm overrides any wrap so the next alarm starts in phase 0, tone high
  always_ff @(posedge clock_50 or negedge reset) begin
    if (!reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      tone_cnt    <= '0;
      tone_low    <= 1'b0;
    end else if (!alarm) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      tone_cnt    <= '0;
      tone_low    <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
      tone_cnt    <= '0;
      tone_low    <= 1'b0;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
      if (tone_cnt == TONE_LAST) begin
        tone_cnt <= '0;
        tone_low <= ~tone_low;
      end else begin
        tone_cnt <= tone_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    seg_d    = SEG_BLANK;
    an_d     = digit_sel ? 2'b01 : 2'b10;
    buzzer_d = alarm & ~blink_phase & ~tone_low;
    if (!(alarm && blink_phase)) begin
      if (!digit_sel)
        seg_d = bcd_to_seg(digit_l);
      else if ((BLANK_LZ != 0) && (digit_h == 4'd0))
        seg_d = SEG_BLANK;
      else
        seg_d = bcd_to_seg(digit_h);
    end
  end

  // Stage p4: registered pin drivers, one cycle behind the scan/alarm state
  always_ff @(posedge clock_50 or negedge reset) begin
    if (!reset) begin
      seg    <= SEG_BLANK;
      an     <= 2'b11;
      buzzer <= 1'b0;
      err    <= 1'b0;
    end else begin
      seg    <= seg_d;
      an     <= an_d;
      buzzer <= buzzer_d;
      err    <= err | (digit_h > 4'd9) | (digit_l > 4'd9);
    end
  end

endmodule

// File: tb/tb_countdown_display.sv
// Self-checking bench for countdown_display: directed and random steps checked
// cycle by cycle against an arithmetic model of the display/alarm behaviour.
module tb_countdown_display;

  localparam int SCAN  = 4;
  localparam int TONE  = 2;
  localparam int BLINK = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] TimeH, TimeL;
  logic       beep;
  logic [6:0] seg;
  logic [1:0] an;
  logic       buzzer, err;

  int n_checks = 0;
  int n_fail   = 0;

  // model state: displayed value, alarm-age, sticky error, previous-cycle index
  logic [8:0] m_disp, m_h1, m_h2;
  int         m_n, m_cyc;
  bit         m_err;

  countdown_display #(
    .SCAN_DIV(SCAN), .TONE_DIV(TONE), .BLINK_DIV(BLINK), .BLANK_LZ(1)
  ) dut (
    .clock_50(clk), .reset(reset), .TimeH(TimeH), .TimeL(TimeL), .beep(beep),
    .seg(seg), .an(an), .buzzer(buzzer), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: return 7'h40;  4'd1: return 7'h79;  4'd2: return 7'h24;
      4'd3: return 7'h30;  4'd4: return 7'h19;  4'd5: return 7'h12;
      4'd6: return 7'h02;  4'd7: return 7'h78;  4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input logic [8:0] d, input bit tens, input int n);
    logic [3:0] dig;
    if (d[8] && ((n / BLINK) % 2 == 1)) return 7'h7F;
    dig = tens ? d[7:4] : d[3:0];
    if (tens && dig == 4'd0) return 7'h7F;
    return seg_of(dig);
  endfunction

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_init();
    m_disp = '0; m_h1 = '0; m_h2 = '0;
    m_n = 0; m_cyc = 0; m_err = 1'b0;
  endtask

  // One clock: outputs after the edge reflect the model state of the cycle before it
  task automatic step();
    logic [8:0] x, nd;
    bit         tens, bad, e_buz;
    x = {beep, TimeH, TimeL};
    @(posedge clk); #1;
    tens  = ((m_cyc / SCAN) % 2) == 1;
    bad   = (m_disp[7:4] > 9) || (m_disp[3:0] > 9);
    e_buz = m_disp[8] && ((m_n / BLINK) % 2 == 0) && (((m_n % BLINK) / TONE) % 2 == 0);
    chk("an",     8'(an),     tens ? 8'h01 : 8'h02);
    chk("seg",    8'(seg),    8'(exp_seg(m_disp, tens, m_n)));
    chk("buzzer", 8'(buzzer), 8'(e_buz));
    chk("err",    8'(err),    8'(m_err | bad));
    // inputs sampled at the last two edges must agree before they are shown
    nd    = (m_h2 == m_h1) ? m_h2 : m_disp;
    m_n   = m_disp[8] ? m_n + 1 : 0;
    m_err = m_err | bad;
    m_h2  = m_h1;
    m_h1  = x;
    m_disp = nd;
    m_cyc++;
  endtask

  task automatic steps(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_seg"}, 8'(seg), 8'h7F);
    chk({tag, "_an"},  8'(an),  8'h03);
    chk({tag, "_buz"}, 8'(buzzer), 8'h00);
    chk({tag, "_err"}, 8'(err), 8'h00);
  endtask

  initial begin
    TimeH = 4'd0; TimeL = 4'd0; beep = 1'b0;
    reset = 1'b1;
    #1 reset = 1'b0;
    #2 chk_reset_outputs("rst_async");
    @(posedge clk); @(posedge clk); #1;
    chk_reset_outputs("rst_held");

    // 1/5, no alarm
    TimeH = 4'd1; TimeL = 4'd5; beep = 1'b0;
    model_init();
    reset = 1'b1;
    steps(20);

    // leading-zero blanking
    TimeH = 4'd0; TimeL = 4'd7;
    steps(16);

    // one-clock glitch must be ignored, three-clock hold accepted
    TimeL = 4'd8; step();
    TimeL = 4'd7; steps(8);
    TimeL = 4'd3; steps(10);

    // alarm at 00: two blink phases, then release
    TimeH = 4'd0; TimeL = 4'd0; beep = 1'b1;
    steps(40);
    beep = 1'b0;
    steps(10);

    // non-BCD digit sets sticky err
    TimeL = 4'hC; steps(10);
    TimeH = 4'd1; TimeL = 4'd2; steps(10);

    // random input changes, glitches and alarms
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        TimeH = 4'($urandom_range(0, 9));
        TimeL = 4'($urandom_range(0, 10));
        beep  = ($urandom_range(0, 3) == 0);
      end
      step();
    end

    // reset in the middle of an alarm takes effect before the next edge
    TimeH = 4'd0; TimeL = 4'd0; beep = 1'b1;
    steps(22);
    #2 reset = 1'b0;
    #1 chk_reset_outputs("rst_mid");
    @(posedge clk); #1;
    chk_reset_outputs("rst_mid_held");
    TimeH = 4'd2; TimeL = 4'd0; beep = 1'b0;
    model_init();
    reset = 1'b1;
    steps(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/countdown_display.md
Name: countdown_display

Overview:
- Display and alarm back-end for the two-digit BCD countdown timer; consumes the timer's TimeH, TimeL and beep outputs.
- Drives a multiplexed two-digit common-anode seven-segment display and a piezo buzzer, all from the fast board clock.
- Inputs come from the slow-clock counter domain, so the block synchronises them and accepts only stable values.
- While beep is asserted, the display flashes and the buzzer emits a gated square-wave tone.

Parameters:
SCAN_DIV, 25000, clock cycles per digit slot (1 kHz digit toggle at 50 MHz)
TONE_DIV, 12500, clock cycles per buzzer half-period (2 kHz tone at 50 MHz)
BLINK_DIV, 12500000, clock cycles per alarm blink half-period (2 Hz blink at 50 MHz)
BLANK_LZ, 1, 1 = blank the high digit when it is 0

Ports:
clock_50  input  1  board clock, rising edge
reset  input  1  asynchronous, active-low reset
TimeH  input  4  BCD tens digit from the counter
TimeL  input  4  BCD units digit from the counter
beep  input  1  alarm request from the counter (count reached 00)
seg  output  7  segments {g,f,e,d,c,b,a}, active low
an  output  2  digit enables, active low; an[0] = units, an[1] = tens
buzzer  output  1  buzzer drive
err  output  1  sticky flag: a non-BCD digit was accepted

Behaviour:
- Reset (reset=0, asynchronous) clears the following:
  - Outputs: seg=7'h7F, an=2'b11, buzzer=0, err=0.
  - All counters, both sync stages and the display register (value 8'h00, alarm 0).
  - digit_sel=0, blink phase=0.
- Input capture:
  - Two-stage sync of the 9-bit vector {beep,TimeH,TimeL}: s1 <= inputs, s2 <= s1.
  - The display register loads s2 only when s2==s1 (stable for 2 cycles).
  - An input change appears in the display register 3 clocks later, provided it is held for at least 3 clocks.
- Scan:
  - scan_cnt counts 0..SCAN_DIV-1 and wraps; at the wrap, digit_sel toggles.
  - digit_sel=0 selects units (an=2'b10); digit_sel=1 selects tens (an=2'b01).
  - seg and an are registered and reflect digit_sel/state from the previous cycle (1-cycle latency).
  - The first active output after reset release is units, with an=2'b10.
- Decode, active low:
  - Digits: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex).
  - Digits A-F display a dash (7'h3F).
  - Blank is 7'h7F.
- Leading zero: when BLANK_LZ=1 and the tens digit is 0, the tens slot outputs blank; an is still driven.
- err: set the cycle after the display register holds any nibble >9. It clears only on reset.
- Alarm (display-register alarm bit = 1):
  - blink_cnt counts 0..BLINK_DIV-1; at the wrap, the phase toggles.
  - Phase 0: normal digits shown; buzzer = tone square wave (toggles every TONE_DIV cycles, starting high on the first cycle of phase 0).
  - Phase 1: seg=7'h7F and buzzer=0; the scan continues (an keeps cycling).
- No alarm (alarm bit = 0): blink_cnt, phase and tone counter are held at 0, and buzzer=0.
  - Each new alarm therefore starts in phase 0 with the tone high.
- Simultaneous events:
  - A scan wrap and a blink wrap in the same cycle are applied together.
  - An alarm deassertion takes priority over any blink or tone wrap in the same cycle.
- Reset mid-operation: everything returns to the reset values immediately, with no wait for the clock.
- Widths: each counter is sized to hold its DIV-1. DIV values must be at least 2.

Test Plan:
(Bench parameters: SCAN_DIV=4, TONE_DIV=2, BLINK_DIV=16, BLANK_LZ=1.)
- Reset low, then high with TimeH/TimeL=1/5, beep=0 -> after 3 clocks display register=8'h15. Outputs alternate every 4 clocks: an=10/seg=12, then an=01/seg=79. buzzer stays 0.
- Inputs 0/7 -> tens slot seg=7F (blanked) with an=01; units slot seg=78.
- Glitch: TimeL changes for 1 clock, then returns -> display register unchanged. A 3-clock hold -> updated exactly 3 clocks after the change.
- beep=1 with 0/0:
  - Phase 0 (16 clocks): units slot seg=40; buzzer toggles every 2 clocks, starting at 1.
  - Phase 1 (16 clocks): seg=7F, buzzer=0, an still cycling.
  - beep=0 -> buzzer=0 and phase 0 within 4 clocks.
- Inputs TimeL=4'hC -> seg=3F in the units slot; err=1 and it stays 1 after returning to valid BCD, until reset.
- Reset asserted mid-alarm -> seg=7F, an=11, buzzer=0, err=0 immediately, before any clock edge.
